// File: rtl/sdrm_fifo_drain_pkg.sv
// sdrm_fifo_drain_pkg: shared bus/FIFO geometry and drain FSM encoding
package sdrm_fifo_drain_pkg;
    localparam int SDRM_BUS   = 32;
    localparam int FIFO_W     = 36;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {IDLE, REQ, READ, WAIT_DONE} state_t;

    // usedw wraps to 0 when the FIFO is full, so the full flag supplies the missing bit
    function automatic logic [4:0] eff_fill(input logic full, input logic [3:0] usedw);
        return full ? 5'(FIFO_DEPTH) : {1'b0, usedw};
    endfunction
endpackage

// File: rtl/sdrm_fifo_drain.sv
// sdrm_fifo_drain: drains sdrm_fifo into SDRAM write bursts; full bursts first, flush drains a partial
module sdrm_fifo_drain
    import sdrm_fifo_drain_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 22,
    parameter int ADDR_SPAN = 2**ADDR_W
) (
    input  logic                clk_100,
    input  logic                rst_n,
    input  logic [FIFO_W-1:0]   fifo_q,
    input  logic [3:0]          fifo_usedw,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                fifo_rdreq,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                wr_req,
    input  logic                wr_ack,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [3:0]          wr_len,
    output logic [SDRM_BUS-1:0] wr_data,
    output logic                wr_data_vld,
    input  logic                wr_done,
    output logic                busy
);
    localparam logic [4:0]      BL   = 5'(BURST_LEN);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(ADDR_SPAN);

    state_t            state, state_nx;
    logic [4:0]        fill;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] base_q;
    logic              base_pend;
    logic              start_full, start;
    logic              rd;
    logic [ADDR_W:0]   addr_nx, addr_end;
    logic              unused_q_hi;

    assign unused_q_hi = ^fifo_q[FIFO_W-1:SDRM_BUS];
    assign fill        = eff_fill(fifo_full, fifo_usedw);
    assign start_full  = fill >= BL;
    assign start       = start_full || (flush && fill != 5'd0);
    assign rd          = state == READ && !fifo_empty;
    assign fifo_rdreq  = rd;
    assign wr_req      = state == REQ;
    assign busy        = state != IDLE;
    assign addr_nx     = {1'b0, wr_addr} + (ADDR_W+1)'(wr_len);
    assign addr_end    = {1'b0, base_q} + SPAN;

    always_ff @(posedge clk_100 or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? REQ : IDLE;
            REQ:       state_nx = wr_ack ? READ : REQ;
            READ:      state_nx = (rd && cnt == 4'd1) ? WAIT_DONE : READ;
            WAIT_DONE: state_nx = wr_done ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end

    // base_addr is captured once after reset and again at every wrap
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            base_q      <= '0;
            base_pend   <= 1'b1;
            wr_len      <= '0;
            cnt         <= '0;
            wr_data     <= '0;
            wr_data_vld <= 1'b0;
        end else begin
            wr_data_vld <= rd;
            if (rd) wr_data <= fifo_q[SDRM_BUS-1:0];
            if (state == IDLE && base_pend) begin
                base_q    <= base_addr;
                wr_addr   <= base_addr;
                base_pend <= 1'b0;
            end
            if (state == IDLE && start) wr_len <= start_full ? BL[3:0] : fill[3:0];
            if (state == REQ && wr_ack) cnt <= wr_len;
            else if (rd) cnt <= cnt - 4'd1;
            if (state == WAIT_DONE && wr_done) begin
                if (addr_nx >= addr_end) begin
                    wr_addr <= base_addr;
                    base_q  <= base_addr;
                end else begin
                    wr_addr <= addr_nx[ADDR_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_sdrm_fifo_drain.sv
// tb_sdrm_fifo_drain: FIFO model, SDRAM controller model and burst-level scoreboard around sdrm_fifo_drain
module tb_sdrm_fifo_drain;
    localparam int BL   = 8;
    localparam int AW   = 12;
    localparam int SPAN = 16;

    logic          clk_100 = 1'b0;
    logic          rst_n;
    logic [35:0]   fifo_q;
    logic [3:0]    fifo_usedw;
    logic          fifo_full, fifo_empty, fifo_rdreq, flush;
    logic [AW-1:0] base_addr;
    logic          wr_req, wr_ack, wr_data_vld, wr_done, busy;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_len;
    logic [31:0]   wr_data;

    always #5 clk_100 = ~clk_100;

    sdrm_fifo_drain #(.BURST_LEN(BL), .ADDR_W(AW), .ADDR_SPAN(SPAN)) dut (
        .clk_100(clk_100), .rst_n(rst_n),
        .fifo_q(fifo_q), .fifo_usedw(fifo_usedw), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .flush(flush), .base_addr(base_addr),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_done(wr_done), .busy(busy)
    );

    // sdrm_fifo model: 16 deep, head word on q, pops logged in read order
    logic [35:0] mem [16];
    logic [3:0]  rp = '0, wp = '0;
    logic [4:0]  cnt_m = '0;
    logic        push = 1'b0;
    logic [31:0] pdata = '0;
    logic [31:0] rd_log [$];
    logic        pop;

    assign pop        = fifo_rdreq && cnt_m != 5'd0;
    assign fifo_q     = mem[rp];
    assign fifo_usedw = cnt_m[3:0];
    assign fifo_full  = cnt_m[4];
    assign fifo_empty = cnt_m == 5'd0;

    always @(posedge clk_100) begin
        if (pop) rd_log.push_back(mem[rp][31:0]);
        if (push) mem[wp] <= {4'hA, pdata};
        rp    <= rp + 4'(pop);
        wp    <= wp + 4'(push);
        cnt_m <= cnt_m + 5'(push) - 5'(pop);
    end

    int            checks = 0, errors = 0;
    int            nb = 0, rdc = 0, got = 0, cur_len = 0, age = 0, dwait = 0;
    int            exp_addr = 0, mbase = 0, pfill = 0, rd_idx = 0;
    logic          acked = 1'b0, preq = 1'b0, pbusy = 1'b0, pflush = 1'b0, stray = 1'b0;
    logic [AW-1:0] paddr = '0, a0;
    logic [3:0]    plen = '0;
    logic [31:0]   last_data = '0;
    int            addr_log [$];
    int            nbs;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_req"}, 64'(wr_req), 0);
        check({tag, "_rdreq"}, 64'(fifo_rdreq), 0);
        check({tag, "_vld"}, 64'(wr_data_vld), 0);
        check({tag, "_len"}, 64'(wr_len), 0);
        check({tag, "_addr"}, 64'(wr_addr), 0);
        check({tag, "_data"}, 64'(wr_data), 0);
    endtask

    // deassert reset; the first IDLE cycle takes base_addr as the write pointer
    task automatic release_rst();
        @(negedge clk_100);
        rst_n = 1'b1;
        exp_addr = int'(base_addr); mbase = int'(base_addr);
        acked = 1'b0; age = 0; got = 0; cur_len = 0; stray = 1'b0;
        wr_ack = 1'b0; wr_done = 1'b0;
        rd_idx = rd_log.size();
        preq = 1'b0; pbusy = 1'b0; pfill = int'(cnt_m); pflush = flush;
        @(posedge clk_100);
        #1;
    endtask

    task automatic tick();
        @(negedge clk_100);
        if (!pbusy)
            check("start", 64'(busy), 64'(pfill >= BL || (pflush && pfill != 0)));
        if (wr_req && !preq) begin
            nb++; rdc = 0; got = 0; cur_len = int'(wr_len);
            check("gap", 64'(pbusy), 0);
            check("len", 64'(wr_len), 64'(pfill >= BL ? BL : pfill));
            check("addr", 64'(wr_addr), 64'(exp_addr));
            addr_log.push_back(int'(wr_addr));
        end
        if (wr_req && preq) check("hold", 64'({wr_addr, wr_len}), 64'({paddr, plen}));
        if (fifo_rdreq) rdc++;
        check("rd_empty", 64'(fifo_rdreq & fifo_empty), 0);
        if (wr_data_vld) begin
            check("vld_acked", 64'(acked), 1);
            got++;
            last_data = wr_data;
            check("data_src", 64'(rd_idx < rd_log.size()), 1);
            if (rd_idx < rd_log.size()) begin
                check("data", 64'(wr_data), 64'(rd_log[rd_idx]));
                rd_idx++;
            end
        end
        preq = wr_req; pbusy = busy; pfill = int'(cnt_m); pflush = flush;
        paddr = wr_addr; plen = wr_len;
        @(posedge clk_100);
        #1;
        push = 1'b0;
        wr_ack = 1'b0;
        wr_done = stray;
        stray = 1'b0;
        if (wr_req) begin
            age++;
            if (age == 2) begin
                wr_ack = 1'b1; acked = 1'b1; dwait = $urandom_range(0, 3);
            end
        end else age = 0;
        if (acked && got >= cur_len) begin
            if (dwait > 0) dwait--;
            else begin
                wr_done = 1'b1; acked = 1'b0;
                check("beats", 64'(got), 64'(cur_len));
                if (exp_addr + cur_len >= mbase + SPAN) begin
                    exp_addr = int'(base_addr); mbase = int'(base_addr);
                end else exp_addr += cur_len;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; base_addr = 12'h100; wr_ack = 1'b0; wr_done = 1'b0;
        repeat (2) @(posedge clk_100);
        #1;
        check_zero("rst");
        release_rst();
        // nine words 34,37,..,58: one full burst, one word left
        for (int i = 0; i < 9; i++) begin
            push = 1'b1; pdata = 32'(34 + 3 * i);
            tick();
        end
        repeat (25) tick();
        check("b1_count", 64'(nb), 1);
        check("b1_last", 64'(last_data), 55);
        check("b1_usedw", 64'(fifo_usedw), 1);
        flush = 1'b1;
        repeat (15) tick();
        flush = 1'b0;
        check("b2_count", 64'(nb), 2);
        check("b2_last", 64'(last_data), 58);
        check("b2_addr", 64'(addr_log[1]), 64'h108);
        check("b2_empty", 64'(fifo_empty), 1);
        // fill to 16 while held in reset, then three full bursts across the 16-word span
        rst_n = 1'b0;
        addr_log.delete();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; pdata = 32'(100 + i);
            @(posedge clk_100);
            #1;
        end
        push = 1'b0;
        check("full_flag", 64'(fifo_full), 1);
        check("full_usedw", 64'(fifo_usedw), 0);
        release_rst();
        repeat (50) tick();
        check("ff_count", 64'(addr_log.size()), 2);
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; pdata = 32'(200 + i);
            tick();
        end
        repeat (30) tick();
        check("wrap_count", 64'(addr_log.size()), 3);
        check("wrap_a0", 64'(addr_log[0]), 64'h100);
        check("wrap_a1", 64'(addr_log[1]), 64'h108);
        check("wrap_a2", 64'(addr_log[2]), 64'h100);
        // reset during the 4th READ cycle
        rdc = 0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; pdata = 32'(300 + i);
            tick();
        end
        for (int k = 0; k < 40 && rdc < 3; k++) tick();
        check("read3", 64'(rdc), 3);
        #1 rst_n = 1'b0;
        #1 check_zero("mid");
        release_rst();
        repeat (10) tick();
        check("post_idle", 64'(busy), 0);
        check("post_usedw", 64'(fifo_usedw), 5);
        // drain the leftovers, then flush on an empty FIFO plus a stray wr_done
        flush = 1'b1;
        repeat (25) tick();
        check("fl_empty", 64'(fifo_empty), 1);
        check("fl_addr", 64'(wr_addr), 64'h105);
        a0 = wr_addr; nbs = nb;
        stray = 1'b1;
        repeat (6) tick();
        flush = 1'b0;
        check("stray_nb", 64'(nb), 64'(nbs));
        check("stray_addr", 64'(wr_addr), 64'(a0));
        // random traffic; the new base only takes effect at the next wrap
        base_addr = 12'h200;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 45 && cnt_m < 5'd16) begin
                push = 1'b1; pdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) flush = !flush;
            tick();
        end
        flush = 1'b1;
        repeat (60) tick();
        flush = 1'b0;
        check("end_empty", 64'(fifo_empty), 1);
        check("end_idle", 64'(busy), 0);
        check("end_addr", 64'(wr_addr), 64'(exp_addr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdrm_fifo_drain.md
SDRM_FIFO_DRAIN -- requirements
Module: sdrm_fifo_drain

Interface
REQ-001 Parameter BURST_LEN, default 8: words per full SDRAM write burst; legal values 1..15.
REQ-002 Parameter ADDR_W, default 22: SDRAM word-address width.
REQ-003 Parameter ADDR_SPAN, default 2**ADDR_W: number of words in the write region before the address wraps.
REQ-004 clk_100  in  1  system clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 fifo_q  in  36  sdrm_fifo read data; bits [`SDRM_BUS-1:0] are payload, upper bits ignored.
REQ-007 fifo_usedw  in  4  sdrm_fifo fill level.
REQ-008 fifo_full  in  1  sdrm_fifo full flag.
REQ-009 fifo_empty  in  1  sdrm_fifo empty flag.
REQ-010 fifo_rdreq  out  1  sdrm_fifo read strobe.
REQ-011 flush  in  1  level request to drain a partial burst.
REQ-012 base_addr  in  ADDR_W  start of the write region; sampled only in reset-release IDLE and on wrap.
REQ-013 wr_req  out  1  burst request to the SDRAM controller.
REQ-014 wr_ack  in  1  controller accepts the request.
REQ-015 wr_addr  out  ADDR_W  burst start address, stable while wr_req is high.
REQ-016 wr_len  out  4  burst length, stable while wr_req is high.
REQ-017 wr_data  out  `SDRM_BUS  burst payload word.
REQ-018 wr_data_vld  out  1  wr_data is valid this cycle.
REQ-019 wr_done  in  1  one-cycle pulse: controller finished the burst.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, REQ, READ, WAIT_DONE.
REQ-022 Effective fill level = 16 when fifo_full is high, otherwise fifo_usedw.
REQ-023 IDLE -> REQ when fill >= BURST_LEN; length latched = BURST_LEN.
REQ-024 IDLE -> REQ when flush is high and 0 < fill < BURST_LEN; length latched = fill.
REQ-025 Full-burst start has priority over flush.
REQ-026 In REQ, hold wr_req high with wr_addr and wr_len stable; on wr_ack, drop wr_req in the following cycle and enter READ.
REQ-027 READ asserts fifo_rdreq for exactly wr_len consecutive cycles, then enters WAIT_DONE.
REQ-028 The FIFO runs in normal (non-show-ahead) mode: wr_data_vld is fifo_rdreq delayed one cycle.
REQ-029 wr_data is registered fifo_q[`SDRM_BUS-1:0] with the same one-cycle alignment.
REQ-030 fifo_rdreq is never asserted while fifo_empty is high.
REQ-031 In WAIT_DONE, on wr_done: wr_addr += wr_len, then enter IDLE.
REQ-032 A wr_done received in any other state is ignored.
REQ-033 Address wrap: if wr_addr + wr_len >= base_addr + ADDR_SPAN, the next wr_addr is base_addr.
REQ-034 Minimum gap between bursts is one IDLE cycle.

Reset
REQ-035 On rst_n low, asynchronously: state = IDLE; wr_req, fifo_rdreq, wr_data_vld and busy = 0; wr_len = 0; wr_data = 0.
REQ-036 On rst_n low, asynchronously: wr_addr = 0; base_addr is loaded in the first IDLE cycle after reset release.
REQ-037 Reset asserted mid-burst abandons the burst; there is no replay and no FIFO rewind.

Structure
REQ-038 SDRM_BUS, the FIFO width (36), the FIFO depth (16) and the state encodings belong in the shared defination.v.
REQ-039 The block is a single module with no sub-modules; the read counter and address adder are inline.

Verification
REQ-040 Scenario: write 9 words 34,37,…,58 into sdrm_fifo; wr_ack is given 2 cycles after wr_req.
  Required response: one burst, wr_len=8, wr_addr=base_addr, wr_data 34..55 on 8 consecutive vld cycles; usedw=1 afterwards.
REQ-041 Scenario: after REQ-040, assert flush.
  Required response: burst with wr_len=1, wr_data=58, wr_addr=base_addr+8; usedw=0 afterwards.
REQ-042 Scenario: fill the FIFO to 16 words (usedw reads 0, fifo_full=1).
  Required response: two back-to-back 8-word bursts; fifo_rdreq never asserted with fifo_empty=1.
REQ-043 Scenario: ADDR_SPAN=16, base_addr=0x100, three full bursts.
  Required response: wr_addr sequence 0x100, 0x108, 0x100.
REQ-044 Scenario: rst_n pulsed low during the 4th READ cycle.
  Required response: all outputs 0 within the same cycle; state IDLE; no wr_data_vld after release until a new wr_ack.
REQ-045 Scenario: flush with the FIFO empty, and a stray wr_done while in IDLE.
  Required response: no wr_req; wr_addr unchanged.
